// File: rtl/pw_mem_arbiter_if.sv
// Requester and shared-memory bundle for pw_mem_arbiter.
// slave = arbiter side, master = requesters plus the memory model driving mem_q.
interface pw_mem_arbiter_if;
    logic [3:0]       req;
    logic [3:0]       req_wr;
    logic [3:0][15:0] req_addr;
    logic [3:0][15:0] req_wdata;
    logic [3:0]       gnt;
    logic [3:0]       ack;
    logic [3:0]       err;
    logic [15:0]      rdata;
    logic [15:0]      mem_addr;
    logic             mem_wren;
    logic [15:0]      mem_wdata;
    logic [15:0]      mem_q;

    modport slave (
        input  req, req_wr, req_addr, req_wdata, mem_q,
        output gnt, ack, err, rdata, mem_addr, mem_wren, mem_wdata
    );

    modport master (
        output req, req_wr, req_addr, req_wdata, mem_q,
        input  gnt, ack, err, rdata, mem_addr, mem_wren, mem_wdata
    );
endinterface

// File: rtl/pw_mem_arbiter.sv
// Round-robin 4-requester arbiter for a shared password memory with 2-cycle read latency.
// Define PW_WRITE_LOCK_EN to reject writes from requesters 1-3 (granted, no mem_wren, err+ack).
module pw_mem_arbiter (
    input  logic              clk,
    input  logic              rst,
    pw_mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  last_q, last_d;
    logic        wr_q, wr_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  ack_q, ack_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        mem_wren_q, mem_wren_d;
    logic [1:0]  win;
    logic        lock_hit;
`ifdef PW_WRITE_LOCK_EN
    logic        lock_q, lock_d;
    logic [3:0]  err_q, err_d;
`endif

    // Descending scan so the nearest set bit after last wins; k=4 wraps back to last itself.
    always_comb begin
        win = last_q;
        for (int k = 4; k >= 1; k--) begin
            if (bus.req[last_q + 2'(k)]) win = last_q + 2'(k);
        end
    end

`ifdef PW_WRITE_LOCK_EN
    assign lock_hit = bus.req_wr[win] && (win != 2'd0);
`else
    assign lock_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        wr_d        = wr_q;
        gnt_d       = '0;
        ack_d       = '0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wren_d  = 1'b0;
`ifdef PW_WRITE_LOCK_EN
        lock_d      = lock_q;
        err_d       = '0;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    sel_d       = win;
                    last_d      = win;
                    wr_d        = bus.req_wr[win];
                    mem_addr_d  = bus.req_addr[win];
                    mem_wdata_d = bus.req_wdata[win];
                    mem_wren_d  = bus.req_wr[win] && !lock_hit;
                    gnt_d       = 4'b0001 << win;
`ifdef PW_WRITE_LOCK_EN
                    lock_d      = lock_hit;
`endif
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (wr_q) begin
                    ack_d   = 4'b0001 << sel_q;
`ifdef PW_WRITE_LOCK_EN
                    if (lock_q) err_d = 4'b0001 << sel_q;
`endif
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: state_d = RESP;
            RESP: begin
                rdata_d = bus.mem_q;
                ack_d   = 4'b0001 << sel_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            sel_q       <= 2'd0;
            last_q      <= 2'd3;
            wr_q        <= 1'b0;
            gnt_q       <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wren_q  <= 1'b0;
`ifdef PW_WRITE_LOCK_EN
            lock_q      <= 1'b0;
            err_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            wr_q        <= wr_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wren_q  <= mem_wren_d;
`ifdef PW_WRITE_LOCK_EN
            lock_q      <= lock_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wren  = mem_wren_q;
`ifdef PW_WRITE_LOCK_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = '0;
`endif
endmodule
